// File: rtl/uart_cmd_wrapper.sv
// rtl/uart_cmd_wrapper.sv - 16-bit command receiver / 8-bit response sender over UART
// Contains the 8-bit UART transceiver and the command/response wrapper around it.

module uart #(
    parameter int BAUD_DIV = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    output logic       TX,
    input  logic [7:0] tx_data,
    input  logic       trmt,
    output logic       tx_done,
    output logic [7:0] rx_data,
    output logic       rx_rdy,
    input  logic       clr_rx_rdy
);
    localparam int CW = $clog2(BAUD_DIV + 1);

    logic          rx_ff1, rx_ff2, rx_act;
    logic [CW-1:0] rx_cnt, tx_cnt;
    logic [3:0]    rx_bit, tx_bit;
    logic [7:0]    rx_shift;
    logic [9:0]    tx_shift;
    logic          tx_act;

    assign TX = tx_shift[0];

    // Receiver: counts half a bit from the start edge, then samples mid-bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_ff1   <= 1'b1;
            rx_ff2   <= 1'b1;
            rx_act   <= 1'b0;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
            rx_rdy   <= 1'b0;
        end else begin
            rx_ff1 <= RX;
            rx_ff2 <= rx_ff1;
            if (clr_rx_rdy)
                rx_rdy <= 1'b0;
            if (!rx_act) begin
                if (!rx_ff2) begin
                    rx_act <= 1'b1;
                    rx_cnt <= CW'(BAUD_DIV / 2);
                    rx_bit <= '0;
                end
            end else if (rx_cnt != '0) begin
                rx_cnt <= rx_cnt - CW'(1);
            end else begin
                rx_cnt <= CW'(BAUD_DIV - 1);
                rx_bit <= rx_bit + 4'd1;
                if (rx_bit == 4'd0) begin
                    if (rx_ff2)
                        rx_act <= 1'b0;
                end else if (rx_bit == 4'd9) begin
                    rx_act <= 1'b0;
                    if (rx_ff2) begin
                        rx_data <= rx_shift;
                        rx_rdy  <= 1'b1;
                    end
                end else begin
                    rx_shift <= {rx_ff2, rx_shift[7:1]};
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_shift <= '1;
            tx_act   <= 1'b0;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_done  <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (!tx_act) begin
                if (trmt) begin
                    tx_shift <= {1'b1, tx_data, 1'b0};
                    tx_act   <= 1'b1;
                    tx_cnt   <= CW'(BAUD_DIV - 1);
                    tx_bit   <= '0;
                end
            end else if (tx_cnt != '0) begin
                tx_cnt <= tx_cnt - CW'(1);
            end else begin
                tx_cnt   <= CW'(BAUD_DIV - 1);
                tx_shift <= {1'b1, tx_shift[9:1]};
                if (tx_bit == 4'd9) begin
                    tx_act  <= 1'b0;
                    tx_done <= 1'b1;
                end else begin
                    tx_bit <= tx_bit + 4'd1;
                end
            end
        end
    end
endmodule

module uart_cmd_wrapper #(
    parameter int TO_CLKS  = 100000,
    parameter int TO_W     = $clog2(TO_CLKS + 1),
    parameter int BAUD_DIV = 434
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        send_resp,
    output logic        resp_sent,
    output logic        tx_busy,
    output logic        rx_timeout
);
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT_LO = 2'd1} state_t;

    state_t          state;
    logic [7:0]      high_reg, low_reg, rx_data;
    logic [TO_W-1:0] to_cnt;
    logic            rx_rdy, clr_rx_rdy, trmt, tx_done;

    // rx_rdy must be knocked down on the accepting edge, or WAIT_LO would re-consume it.
    assign clr_rx_rdy = rx_rdy && (state == IDLE || state == WAIT_LO);
    assign trmt       = send_resp & ~tx_busy;
    assign cmd        = {high_reg, low_reg};

    uart #(.BAUD_DIV(BAUD_DIV)) u_uart (
        .clk        (clk),
        .rst_n      (rst_n),
        .RX         (RX),
        .TX         (TX),
        .tx_data    (resp),
        .trmt       (trmt),
        .tx_done    (tx_done),
        .rx_data    (rx_data),
        .rx_rdy     (rx_rdy),
        .clr_rx_rdy (clr_rx_rdy)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            high_reg   <= '0;
            low_reg    <= '0;
            cmd_rdy    <= 1'b0;
            rx_timeout <= 1'b0;
            to_cnt     <= '0;
        end else begin
            rx_timeout <= 1'b0;
            if (clr_cmd_rdy)
                cmd_rdy <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx_rdy) begin
                        high_reg <= rx_data;
                        cmd_rdy  <= 1'b0;
                        to_cnt   <= '0;
                        state    <= WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    to_cnt <= to_cnt + TO_W'(1);
                    if (rx_rdy) begin
                        low_reg <= rx_data;
                        cmd_rdy <= 1'b1;
                        state   <= IDLE;
                    end else if (to_cnt == TO_W'(TO_CLKS - 1)) begin
                        rx_timeout <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_busy   <= 1'b0;
            resp_sent <= 1'b0;
        end else if (trmt) begin
            tx_busy   <= 1'b1;
            resp_sent <= 1'b0;
        end else if (tx_done) begin
            tx_busy   <= 1'b0;
            resp_sent <= 1'b1;
        end
    end
endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// tb/tb_uart_cmd_wrapper.sv - scoreboard bench for uart_cmd_wrapper
module tb_uart_cmd_wrapper;
    localparam int BAUD    = 16;
    localparam int TO_CLKS = 2000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        RX = 1'b1;
    logic        TX;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy = 1'b0;
    logic [7:0]  resp = 8'h00;
    logic        send_resp = 1'b0;
    logic        resp_sent, tx_busy, rx_timeout;

    int          pass_cnt = 0;
    int          total_cnt = 0;
    logic [15:0] exp_cmd_q[$];
    logic [7:0]  exp_tx_q[$];
    logic [7:0]  host_rx_q[$];
    int          to_count = 0;
    longint      cyc = 0;
    longint      to_cyc = 0;

    uart_cmd_wrapper #(.TO_CLKS(TO_CLKS), .BAUD_DIV(BAUD)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .RX          (RX),
        .TX          (TX),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .resp        (resp),
        .send_resp   (send_resp),
        .resp_sent   (resp_sent),
        .tx_busy     (tx_busy),
        .rx_timeout  (rx_timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (rx_timeout === 1'b1) begin
            to_count = to_count + 1;
            to_cyc   = cyc;
        end
    end

    // Host-side receiver on TX.
    always begin
        logic [7:0] b;
        @(negedge TX);
        repeat (BAUD / 2) @(negedge clk);
        if (TX === 1'b0) begin
            for (int i = 0; i < 8; i++) begin
                repeat (BAUD) @(negedge clk);
                b[i] = TX;
            end
            repeat (BAUD) @(negedge clk);
            host_rx_q.push_back(b);
        end
    end

    task automatic send_byte(input logic [7:0] b);
        RX = 1'b0;
        repeat (BAUD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (BAUD) @(negedge clk);
        end
        RX = 1'b1;
        repeat (BAUD) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total_cnt++;
        if ({cmd_rdy, resp_sent, tx_busy, rx_timeout, TX} !== 5'b00001)
            $display("FAIL reset_flags got=%b want=00001", {cmd_rdy, resp_sent, tx_busy, rx_timeout, TX});
        else pass_cnt++;
        total_cnt++;
        if (cmd !== 16'h0000) $display("FAIL reset_cmd got=%h want=0000", cmd);
        else pass_cnt++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [15:0] e;
        int t0;
        t0 = to_count;
        exp_cmd_q.push_back(16'hA53C);
        send_byte(8'hA5);
        send_byte(8'h3C);
        e = exp_cmd_q.pop_front();
        total_cnt++;
        if (cmd_rdy !== 1'b1) $display("FAIL b2b_cmd_rdy got=%b want=1", cmd_rdy);
        else pass_cnt++;
        total_cnt++;
        if (cmd !== e) $display("FAIL b2b_cmd got=%h want=%h", cmd, e);
        else pass_cnt++;
        total_cnt++;
        if (to_count !== t0) $display("FAIL b2b_no_timeout got=%0d want=%0d", to_count, t0);
        else pass_cnt++;
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        total_cnt++;
        if (cmd_rdy !== 1'b0) $display("FAIL b2b_clr got=%b want=0", cmd_rdy);
        else pass_cnt++;
        total_cnt++;
        if (cmd !== e) $display("FAIL b2b_cmd_after_clr got=%h want=%h", cmd, e);
        else pass_cnt++;
    endtask

    task automatic test_timeout();
        logic [15:0] e;
        int t0;
        longint tend;
        t0 = to_count;
        send_byte(8'h12);
        tend = cyc;
        repeat (2500) @(negedge clk);
        total_cnt++;
        if (to_count !== t0 + 1) $display("FAIL timeout_count got=%0d want=%0d", to_count - t0, 1);
        else pass_cnt++;
        total_cnt++;
        if (to_cyc - tend < TO_CLKS - 30 || to_cyc - tend > TO_CLKS + 10)
            $display("FAIL timeout_time got=%0d want=~%0d", to_cyc - tend, TO_CLKS);
        else pass_cnt++;
        exp_cmd_q.push_back(16'h3456);
        t0 = to_count;
        send_byte(8'h34);
        send_byte(8'h56);
        e = exp_cmd_q.pop_front();
        total_cnt++;
        if (cmd_rdy !== 1'b1 || cmd !== e)
            $display("FAIL timeout_next_cmd got=%b/%h want=1/%h", cmd_rdy, cmd, e);
        else pass_cnt++;
        total_cnt++;
        if (to_count !== t0) $display("FAIL timeout_spurious got=%0d want=%0d", to_count, t0);
        else pass_cnt++;
    endtask

    task automatic test_set_wins();
        logic [15:0] e;
        bit found;
        exp_cmd_q.push_back(16'hBEEF);
        send_byte(8'hBE);
        total_cnt++;
        if (cmd_rdy !== 1'b0) $display("FAIL overrun_drop got=%b want=0", cmd_rdy);
        else pass_cnt++;
        found = 1'b0;
        fork
            send_byte(8'hEF);
            begin
                for (int n = 0; n < 400 && !found; n++) begin
                    @(negedge clk);
                    if (dut.rx_rdy === 1'b1) found = 1'b1;
                end
                clr_cmd_rdy = found;
                @(negedge clk);
                clr_cmd_rdy = 1'b0;
            end
        join
        e = exp_cmd_q.pop_front();
        total_cnt++;
        if (!found) $display("FAIL set_wins_align got=no_rx_rdy want=rx_rdy");
        else pass_cnt++;
        total_cnt++;
        if (cmd_rdy !== 1'b1 || cmd !== e)
            $display("FAIL set_wins got=%b/%h want=1/%h", cmd_rdy, cmd, e);
        else pass_cnt++;
    endtask

    task automatic test_tx();
        logic [7:0] e, h;
        int n;
        exp_tx_q.push_back(8'hA5);
        resp = 8'hA5;
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
        resp = 8'h00;
        total_cnt++;
        if (tx_busy !== 1'b1 || resp_sent !== 1'b0)
            $display("FAIL tx_start got=%b%b want=10", tx_busy, resp_sent);
        else pass_cnt++;
        repeat (50) @(negedge clk);
        resp = 8'hFF;
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
        total_cnt++;
        if (tx_busy !== 1'b1) $display("FAIL tx_ignore_busy got=%b want=1", tx_busy);
        else pass_cnt++;
        n = 0;
        while (resp_sent !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        total_cnt++;
        if (resp_sent !== 1'b1 || tx_busy !== 1'b0)
            $display("FAIL tx_done got=%b%b want=01", tx_busy, resp_sent);
        else pass_cnt++;
        repeat (250) @(negedge clk);
        total_cnt++;
        if (host_rx_q.size() !== 1) $display("FAIL tx_byte_count got=%0d want=1", host_rx_q.size());
        else pass_cnt++;
        if (host_rx_q.size() > 0) begin
            h = host_rx_q.pop_front();
            e = exp_tx_q.pop_front();
            total_cnt++;
            if (h !== e) $display("FAIL tx_byte got=%h want=%h", h, e);
            else pass_cnt++;
        end
        total_cnt++;
        if (resp_sent !== 1'b1) $display("FAIL tx_sent_hold got=%b want=1", resp_sent);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        logic [15:0] e;
        send_byte(8'h77);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if ({cmd_rdy, resp_sent, tx_busy, rx_timeout, TX} !== 5'b00001 || cmd !== 16'h0000)
            $display("FAIL reset_mid got=%b/%h want=00001/0000",
                      {cmd_rdy, resp_sent, tx_busy, rx_timeout, TX}, cmd);
        else pass_cnt++;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        exp_cmd_q.push_back(16'h0102);
        send_byte(8'h01);
        send_byte(8'h02);
        e = exp_cmd_q.pop_front();
        total_cnt++;
        if (cmd_rdy !== 1'b1 || cmd !== e)
            $display("FAIL reset_next_cmd got=%b/%h want=1/%h", cmd_rdy, cmd, e);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_timeout();
        test_set_wins();
        test_tx();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/uart_cmd_wrapper.md
Name: uart_cmd_wrapper

Overview:
- DUT-side counterpart of the host command link.
- Receives a 16-bit command over serial RX as two UART bytes, high byte first, and presents it as a parallel word with a ready flag.
- Transmits the 8-bit response byte back on TX when the consumer requests it.
- Instantiates the team's 8-bit UART transceiver and adds byte assembly, an inter-byte timeout and transmit-busy tracking.

Parameters:
TO_CLKS, 100000, max clocks allowed between high-byte and low-byte rx_rdy before the partial command is discarded (must be > 1 UART byte time)
TO_W, $clog2(TO_CLKS+1), width of timeout counter

Ports:
clk  input  1  system clock, all flops on rising edge
rst_n  input  1  asynchronous active-low reset
RX  input  1  serial data in, to UART receiver
TX  output  1  serial data out, from UART transmitter
cmd  output  16  assembled command {high_byte, low_byte}
cmd_rdy  output  1  registered flag, new cmd valid
clr_cmd_rdy  input  1  consumer knocks down cmd_rdy
resp  input  8  response byte to transmit
send_resp  input  1  one-cycle request to transmit resp
resp_sent  output  1  registered flag, response transmission complete
tx_busy  output  1  response transmission in progress
rx_timeout  output  1  one-cycle pulse, partial command discarded

Behaviour:
- Reset: state=IDLE; cmd=16'h0000; cmd_rdy=0; resp_sent=0; tx_busy=0; rx_timeout=0; timeout counter=0. TX idles high via the UART.
- UART hookup: tx_data=resp; trmt=send_resp & ~tx_busy; clr_rx_rdy driven by this block's SM, one-cycle pulse per byte consumed.
- Rx SM states:
  - IDLE: wait for first byte. On rx_rdy: high_reg<=rx_data, clr_rx_rdy=1, cmd_rdy<=0, counter<=0, go WAIT_LO.
  - WAIT_LO: counter increments each clock.
    - On rx_rdy: low_reg<=rx_data, clr_rx_rdy=1, cmd_rdy<=1 (visible 1 clk after rx_rdy), go IDLE.
    - Else if counter==TO_CLKS-1: rx_timeout pulses 1 clk, go IDLE; low_reg keeps its old value.
    - rx_rdy on the same cycle as terminal count: rx_rdy wins; the byte is accepted and no timeout fires.
  - Illegal encoding goes to IDLE.
- cmd = {high_reg, low_reg}. high_reg changes on the same edge that clears cmd_rdy, so cmd is stable whenever cmd_rdy=1.
- cmd_rdy clear:
  - cmd_rdy<=0 on clr_cmd_rdy, or on a new high byte accepted in IDLE.
  - A set (low byte accepted) in the same cycle as clr_cmd_rdy: set wins.
  - cmd_rdy left high while a new command arrives: flag drops on the high byte and re-sets on the low byte (overrun is not flagged).
- Tx path:
  - Accepted send_resp (tx_busy=0): trmt pulses the same cycle, tx_busy<=1, resp_sent<=0.
  - UART tx_done: tx_busy<=0, resp_sent<=1; resp_sent holds until the next accepted send_resp.
  - send_resp while tx_busy=1 is ignored: no trmt, no state change.
  - resp need only be valid in the send_resp cycle, because the UART latches it on trmt.
- Rx and Tx paths are fully independent and may operate concurrently.
- Async reset mid-byte or mid-transmission: all flags clear and the SM returns to IDLE. A partially received command is lost, and a response in flight is aborted by the UART reset.

Test Plan:
- Host sends bytes 8'hA5 then 8'h3C back-to-back -> cmd_rdy rises 1 clk after the 2nd rx_rdy, cmd=16'hA53C, rx_timeout never pulses; clr_cmd_rdy then drops cmd_rdy with cmd still 16'hA53C.
- TO_CLKS=2000: send 8'h12, wait 2500 clks, then send 8'h34, 8'h56 -> rx_timeout pulses once ~2000 clks after the first rx_rdy; the later cmd=16'h3456, cmd_rdy=1.
- Command 16'hBEEF with clr_cmd_rdy asserted exactly in the cycle the low byte is accepted -> cmd_rdy=1 (set wins).
- Pulse send_resp with resp=8'hA5 -> tx_busy=1 next clk; host receives 8'hA5; resp_sent=1 the clk after tx_done; tx_busy=0.
- Second send_resp with resp=8'hFF mid-transmission of 8'hA5 -> ignored; host receives only 8'hA5.
- Assert rst_n low for 3 clks after a high byte of 8'h77 -> all outputs at reset values; the next full command 16'h0102 is assembled correctly.
